// File: rtl/serial_pkg.sv
// Shared definitions for the bit-serial subtractor.
package serial_pkg;

    // Controller states; IDLE is the reset state.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Width of a counter that can hold values 0..width.
    function automatic int unsigned cnt_width(input int unsigned width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/adder_1bit.sv
// Single full-adder cell: sum and majority carry of three input bits.
module adder_1bit (
    input  logic a,
    input  logic b,
    input  logic carry_in,
    output logic sum,
    output logic carry_out
);

    assign sum       = a ^ b ^ carry_in;
    assign carry_out = (a & b) | (a & carry_in) | (b & carry_in);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial a - b - borrow_in, LSB first, one full-adder cell, start/done handshake.
module serial_subtractor
    import serial_pkg::*;
#(
    parameter int BIT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic                 start,
    input  logic [BIT_WIDTH-1:0] a,
    input  logic [BIT_WIDTH-1:0] b,
    input  logic                 borrow_in,
    output logic                 busy,
    output logic                 done,
    output logic [BIT_WIDTH-1:0] diff,
    output logic                 borrow_out,
    output logic                 overflow
);

    localparam int unsigned   CW   = cnt_width(BIT_WIDTH);
    localparam logic [CW-1:0] LAST = CW'(BIT_WIDTH - 1);

    state_t                 r_state;
    state_t                 w_next;
    logic                   w_load;
    logic                   w_shift;
    logic                   w_last;

    logic [BIT_WIDTH-1:0]   r_opa;
    logic [BIT_WIDTH-1:0]   r_opnb;
    // Holds the result bits already produced; the final bit is combined
    // on the last cycle, so only BIT_WIDTH-1 bits need storage.
    logic [BIT_WIDTH-2:0]   r_res;
    logic                   r_carry;
    logic [CW-1:0]          r_cnt;

    logic                   w_sum;
    logic                   w_cout;
    logic [BIT_WIDTH-1:0]   w_res_next;

    adder_1bit u_fa (
        .a         (r_opa[0]),
        .b         (r_opnb[0]),
        .carry_in  (r_carry),
        .sum       (w_sum),
        .carry_out (w_cout)
    );

    assign w_last     = (r_cnt == LAST);
    assign w_res_next = {w_sum, r_res};
    assign busy       = (r_state == SHIFT);
    assign done       = (r_state == DONE);

    // State register.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic and datapath enables.
    always_comb begin
        w_next  = r_state;
        w_load  = 1'b0;
        w_shift = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_load = 1'b1;
                    w_next = SHIFT;
                end
            end
            SHIFT: begin
                w_shift = 1'b1;
                if (w_last) begin
                    w_next = DONE;
                end
            end
            DONE: begin
                if (start) begin
                    w_load = 1'b1;
                    w_next = SHIFT;
                end else begin
                    w_next = IDLE;
                end
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // Operand shift registers, carry and bit counter.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_opa   <= '0;
            r_opnb  <= '0;
            r_res   <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
        end else if (w_load) begin
            r_opa   <= a;
            r_opnb  <= ~b;
            r_carry <= ~borrow_in;
            r_cnt   <= '0;
        end else if (w_shift) begin
            r_opa   <= r_opa >> 1;
            r_opnb  <= r_opnb >> 1;
            r_res   <= w_res_next[BIT_WIDTH-1:1];
            r_carry <= w_cout;
            r_cnt   <= r_cnt + 1'b1;
        end
    end

    // Result registers, loaded on the edge entering DONE. On the last bit
    // cycle r_carry is the carry into the MSB and w_cout the carry out of it,
    // so overflow is taken directly from them instead of a separate latch.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            diff       <= '0;
            borrow_out <= 1'b0;
            overflow   <= 1'b0;
        end else if (w_shift && w_last) begin
            diff       <= w_res_next;
            borrow_out <= ~w_cout;
            overflow   <= r_carry ^ w_cout;
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (BIT_WIDTH = 8).
module tb_serial_subtractor;

    localparam int W = 8;

    logic         clk;
    logic         n_rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         borrow_in;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         borrow_out;
    logic         overflow;

    int checks = 0;
    int errors = 0;

    serial_subtractor #(.BIT_WIDTH(W)) dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .start      (start),
        .a          (a),
        .b          (b),
        .borrow_in  (borrow_in),
        .busy       (busy),
        .done       (done),
        .diff       (diff),
        .borrow_out (borrow_out),
        .overflow   (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         bin;
        logic [W-1:0] diff;
        logic         bo;
        logic         ov;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the operand values.
    task automatic model(input logic [W-1:0] x, input logic [W-1:0] y, input logic bi,
                         output logic [W-1:0] d, output logic bo, output logic ov);
        int ud;
        int sd;
        ud = int'(x) - int'(y) - int'(bi);
        sd = int'($signed(x)) - int'($signed(y)) - int'(bi);
        d  = W'(ud);
        bo = (ud < 0);
        ov = (sd < -(1 << (W - 1))) || (sd > (1 << (W - 1)) - 1);
    endtask

    // Protocol invariants sampled every cycle outside reset.
    logic prev_done = 1'b0;
    always @(negedge clk) begin
        if (n_rst) begin
            checks++;
            if (busy && done) begin
                errors++;
                $display("FAIL busy_and_done: busy=%0b done=%0b expected not both", busy, done);
            end
            if (done && prev_done) begin
                errors++;
                $display("FAIL done_twice: done=%0b prev=%0b expected single pulse", done, prev_done);
            end
        end
        prev_done = done;
    end

    // One operation with a one-cycle start; optionally pokes start mid-SHIFT.
    task automatic do_op(input logic [W-1:0] xa, input logic [W-1:0] xb, input logic xbi,
                         input string tag, input int poke_at,
                         output logic [W-1:0] rd, output logic rbo, output logic rov);
        int busy_cnt;
        int pulses;
        busy_cnt = 0;
        pulses   = 0;
        rd  = '0;
        rbo = 1'b0;
        rov = 1'b0;
        @(negedge clk);
        a = xa; b = xb; borrow_in = xbi; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        a = W'($urandom); b = W'($urandom); borrow_in = 1'($urandom);
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (i == poke_at) begin
                start = 1'b1;
                a = W'($urandom); b = W'($urandom); borrow_in = 1'($urandom);
            end
            if (busy) busy_cnt++;
            if (done) begin
                pulses++;
                if (pulses == 1) begin
                    rd  = diff;
                    rbo = borrow_out;
                    rov = overflow;
                end
            end
        end
        start = 1'b0;
        check({tag, "_busy_cycles"}, busy_cnt, W);
        check({tag, "_done_pulses"}, pulses, 1);
    endtask

    vec_t vecs[7];
    logic [W-1:0] rd, ed;
    logic         rbo, rov, ebo, eov;
    logic [W:0]   q[$];
    logic [W:0]   ent;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        n_rst = 1'b0; start = 1'b0; a = '0; b = '0; borrow_in = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_diff", diff, 0);
        check("rst_bo", borrow_out, 0);
        check("rst_ov", overflow, 0);
        n_rst = 1'b1;

        // Directed vectors with hand-derived expectations.
        vecs[0] = '{8'd100, 8'd42,  1'b0, 8'd58,  1'b0, 1'b0};
        vecs[1] = '{8'h80,  8'h01,  1'b0, 8'h7F,  1'b0, 1'b1};
        vecs[2] = '{8'h7F,  8'hFF,  1'b0, 8'h80,  1'b1, 1'b1};
        vecs[3] = '{8'd5,   8'd10,  1'b0, 8'hFB,  1'b1, 1'b0};
        vecs[4] = '{8'd0,   8'd0,   1'b1, 8'hFF,  1'b1, 1'b0};
        vecs[5] = '{8'h80,  8'h7F,  1'b1, 8'h00,  1'b0, 1'b1};
        vecs[6] = '{8'hFF,  8'hFF,  1'b0, 8'h00,  1'b0, 1'b0};
        for (int i = 0; i < 7; i++) begin
            do_op(vecs[i].a, vecs[i].b, vecs[i].bin, $sformatf("vec%0d", i), -1, rd, rbo, rov);
            check($sformatf("vec%0d_diff", i), rd, vecs[i].diff);
            check($sformatf("vec%0d_bo", i), rbo, vecs[i].bo);
            check($sformatf("vec%0d_ov", i), rov, vecs[i].ov);
        end

        // Randomized operands against the integer model.
        for (int i = 0; i < 20; i++) begin
            logic [W-1:0] xa, xb;
            logic xbi;
            xa = W'($urandom); xb = W'($urandom); xbi = 1'($urandom);
            model(xa, xb, xbi, ed, ebo, eov);
            do_op(xa, xb, xbi, $sformatf("rnd%0d", i), -1, rd, rbo, rov);
            check($sformatf("rnd%0d_diff", i), rd, ed);
            check($sformatf("rnd%0d_bo", i), rbo, ebo);
            check($sformatf("rnd%0d_ov", i), rov, eov);
        end

        // start during SHIFT is ignored; result then holds.
        do_op(8'd77, 8'd33, 1'b0, "poke", 3, rd, rbo, rov);
        check("poke_diff", rd, 44);
        check("poke_bo", rbo, 0);
        repeat (3) @(negedge clk);
        check("hold_diff", diff, 44);

        // start held: back-to-back results every W+1 cycles.
        begin
            int pulses;
            int last_cyc;
            pulses = 0;
            last_cyc = -1;
            @(negedge clk);
            a = W'($urandom); b = W'($urandom); borrow_in = 1'($urandom);
            start = 1'b1;
            q.push_back({borrow_in, a ^ b, a});
            q.delete();
            q.push_back({borrow_in, b});
            q.push_back({1'b0, a});
            for (int cyc = 1; cyc < 80 && pulses < 4; cyc++) begin
                @(negedge clk);
                if (done) begin
                    logic [W-1:0] xa, xb;
                    logic xbi;
                    ent = q.pop_front(); xbi = ent[W]; xb = ent[W-1:0];
                    ent = q.pop_front(); xa = ent[W-1:0];
                    model(xa, xb, xbi, ed, ebo, eov);
                    check($sformatf("b2b%0d_diff", pulses), diff, ed);
                    check($sformatf("b2b%0d_bo", pulses), borrow_out, ebo);
                    check($sformatf("b2b%0d_ov", pulses), overflow, eov);
                    if (last_cyc >= 0) check($sformatf("b2b%0d_gap", pulses), cyc - last_cyc, W + 1);
                    last_cyc = cyc;
                    pulses++;
                end
                a = W'($urandom); b = W'($urandom); borrow_in = 1'($urandom);
                if (!busy) begin
                    if (pulses < 4) begin
                        q.push_back({borrow_in, b});
                        q.push_back({1'b0, a});
                    end else begin
                        start = 1'b0;
                    end
                end
            end
            start = 1'b0;
            check("b2b_pulses", pulses, 4);
        end

        // Reset in the middle of an operation clears everything.
        do_op(8'd100, 8'd42, 1'b0, "pre_rst", -1, rd, rbo, rov);
        check("pre_rst_diff", rd, 58);
        @(negedge clk);
        a = 8'd200; b = 8'd1; borrow_in = 1'b0; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (4) @(negedge clk);
        n_rst = 1'b0;
        #1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_diff", diff, 0);
        check("mid_rst_bo", borrow_out, 0);
        check("mid_rst_ov", overflow, 0);
        @(negedge clk);
        n_rst = 1'b1;
        begin
            int seen;
            seen = 0;
            for (int i = 0; i < 12; i++) begin
                @(negedge clk);
                if (done || busy) seen++;
            end
            check("post_rst_idle", seen, 0);
        end
        do_op(8'd5, 8'd10, 1'b0, "post_rst", -1, rd, rbo, rov);
        check("post_rst_diff", rd, 8'hFB);
        check("post_rst_bo", rbo, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
